// File: rtl/inst_fetch_queue_if.sv
// Bridge instruction port, redirect input and decode-side queue head of the fetch front end.
// master is the fetch unit; slave is the bridge/decode/redirect side.
interface inst_fetch_queue_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adef;

    modport master (
        output inst_req, inst_addr, out_valid, out_pc, out_inst, out_adef,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  inst_req, inst_addr, out_valid, out_pc, out_inst, out_adef,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with one outstanding bridge request and an in-order decode queue.
// Redirects flush the queue; a misaligned PC becomes an address-error entry and fetch halts.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input logic                clk,
    input logic                rst_p,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HALT
    } state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [31:0]   req_pc, req_pc_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic          q_adef [DEPTH];

    logic          has_space;
    logic          pc_aligned;
    logic          head_valid;
    logic          flush;
    logic          push;
    logic          pop;
    logic [31:0]   push_pc;
    logic [31:0]   push_inst;
    logic          push_adef;

    assign has_space  = count < FULL;
    assign pc_aligned = pc[1:0] == 2'b00;
    assign head_valid = count != '0;

    // A request only goes out when a queue slot is free, so its returned word always fits.
    assign bus.inst_req  = (state == S_REQ) && has_space && !bus.redirect_valid && pc_aligned;
    assign bus.inst_addr = pc;

    assign bus.out_valid = head_valid && !bus.redirect_valid;
    assign bus.out_pc    = head_valid ? q_pc[rd_ptr]   : 32'h0;
    assign bus.out_inst  = head_valid ? q_inst[rd_ptr] : 32'h0;
    assign bus.out_adef  = head_valid ? q_adef[rd_ptr] : 1'b0;

    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= 32'h0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        flush       = 1'b0;
        push        = 1'b0;
        push_pc     = req_pc;
        push_inst   = bus.inst_rdata;
        push_adef   = 1'b0;

        case (state)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = bus.redirect_pc;
                end else if (!pc_aligned) begin
                    if (has_space) begin
                        push       = 1'b1;
                        push_pc    = pc;
                        push_inst  = 32'h0;
                        push_adef  = 1'b1;
                        state_next = S_HALT;
                    end
                end else if (bus.inst_req && bus.inst_addr_ok) begin
                    req_pc_next = pc;
                    pc_next     = pc + 32'd4;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    pc_next    = bus.redirect_pc;
                    state_next = bus.inst_data_ok ? S_REQ : S_DISCARD;
                end else if (bus.inst_data_ok) begin
                    push       = 1'b1;
                    state_next = S_REQ;
                end
            end
            // The stale response still has to be absorbed before a new request can go out.
            S_DISCARD: begin
                if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    pc_next    = bus.redirect_pc;
                    state_next = bus.inst_data_ok ? S_REQ : S_DISCARD;
                end else if (bus.inst_data_ok) begin
                    state_next = S_REQ;
                end
            end
            S_HALT: begin
                if (bus.redirect_valid) begin
                    flush      = 1'b1;
                    pc_next    = bus.redirect_pc;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Pointers wrap naturally; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            q_pc[wr_ptr]   <= push_pc;
            q_inst[wr_ptr] <= push_inst;
            q_adef[wr_ptr] <= push_adef;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: a bridge model plus a fetch-stream reference model feed
// an expected-entry queue that a separate monitor compares against each decode handshake.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } entry_t;

    logic clk = 1'b0;
    logic rst_p;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    entry_t      exp_q[$];
    logic [31:0] model_pc;
    bit          br_busy;
    bit          br_drop;
    logic [31:0] br_addr;
    int          br_wait;
    int          latency_min;
    int          latency_max;
    int          accept_pct;
    bit          use_word;
    logic [31:0] next_word;
    int          checks;
    int          errors;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_p              = 1'b1;
        bus.inst_addr_ok   = 1'b0;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_out_pc", bus.out_pc, 32'h0);
        checkOutput("rst_out_inst", bus.out_inst, 32'h0);
        checkOutput("rst_out_adef", 32'(bus.out_adef), 32'h0);
        checkOutput("rst_inst_addr", bus.inst_addr, RESET_PC);
        exp_q.delete();
        model_pc = RESET_PC;
        br_busy  = 1'b0;
        br_drop  = 1'b0;
        use_word = 1'b0;
        @(negedge clk);
        rst_p = 1'b0;
    endtask

    // One bus cycle: drive inputs, check the request side against the model, then advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit ready);
        bit data_now;
        bit exp_req;
        bit accept;
        @(negedge clk);
        data_now           = br_busy && (br_wait == 0);
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? rpc : $urandom;
        bus.out_ready      = ready;
        bus.inst_data_ok   = data_now;
        bus.inst_rdata     = (data_now && use_word) ? next_word : $urandom;
        bus.inst_addr_ok   = 1'b0;
        #1;
        exp_req = !br_busy && !redir && (model_pc[1:0] == 2'b00) && (exp_q.size() < DEPTH);
        checkOutput("inst_req", 32'(bus.inst_req), 32'(exp_req));
        if (exp_req) begin
            checkOutput("inst_addr", bus.inst_addr, model_pc);
        end
        accept           = bus.inst_req && ($urandom_range(99) < accept_pct);
        bus.inst_addr_ok = accept;

        if (br_busy) begin
            if (data_now) begin
                if (!br_drop && !redir) begin
                    exp_q.push_back({br_addr, bus.inst_rdata, 1'b0});
                end
                br_busy  = 1'b0;
                use_word = 1'b0;
            end else begin
                br_wait--;
            end
        end
        if (redir) begin
            exp_q.delete();
            model_pc = rpc;
            if (br_busy) begin
                br_drop = 1'b1;
            end
            if (rpc[1:0] != 2'b00) begin
                exp_q.push_back({rpc, 32'h0, 1'b1});
            end
        end else if (accept) begin
            br_busy  = 1'b1;
            br_drop  = 1'b0;
            br_addr  = model_pc;
            br_wait  = $urandom_range(latency_max, latency_min);
            model_pc = model_pc + 32'd4;
        end
    endtask

    always begin
        entry_t e;
        @(negedge clk);
        #2;
        if (!rst_p && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got pc %h inst %h, expected no entry",
                         bus.out_pc, bus.out_inst);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_pc", bus.out_pc, e.pc);
                checkOutput("out_inst", bus.out_inst, e.inst);
                checkOutput("out_adef", 32'(bus.out_adef), 32'(e.adef));
            end
        end
    end

    task automatic randomPhase(input int cycles);
        bit          redir;
        logic [31:0] rpc;
        for (int i = 0; i < cycles; i++) begin
            latency_min = 0;
            latency_max = $urandom_range(3);
            accept_pct  = 70;
            redir       = $urandom_range(99) < 3;
            rpc         = $urandom & 32'hffff_fffc;
            if ($urandom_range(4) == 0) begin
                rpc[1:0] = 2'($urandom_range(3, 1));
            end
            applyStimulus(redir, rpc, $urandom_range(99) < 60);
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst_p              = 1'b1;
        bus.inst_addr_ok   = 1'b0;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        accept_pct         = 100;
        latency_min        = 0;
        latency_max        = 0;
        use_word           = 1'b0;
        next_word          = 32'h0;

        // First fetch: accepted immediately, word returns two cycles later.
        doReset();
        latency_min = 1;
        latency_max = 1;
        use_word    = 1'b1;
        next_word   = 32'h2408_0001;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("tp1_out_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("tp1_out_pc", bus.out_pc, 32'hbfc0_0000);
        checkOutput("tp1_out_inst", bus.out_inst, 32'h2408_0001);
        checkOutput("tp1_next_addr", bus.inst_addr, 32'hbfc0_0004);

        // Fill the queue with decode stalled, then release one entry.
        doReset();
        latency_min = 0;
        latency_max = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
        end
        checkOutput("full_no_req", 32'(bus.inst_req), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_pop_req", 32'(bus.inst_req), 32'h1);
        checkOutput("full_pop_addr", bus.inst_addr, 32'hbfc0_0010);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect while waiting; the late response must be dropped.
        doReset();
        latency_min = 3;
        latency_max = 3;
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0100, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("discard_out_valid", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("discard_new_addr", bus.inst_addr, 32'h8000_0100);

        // Redirect in the same cycle as the response, then a misaligned target and the wrap case.
        doReset();
        latency_min = 0;
        latency_max = 0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0300, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("coinc_req", 32'(bus.inst_req), 32'h1);
        checkOutput("coinc_addr", bus.inst_addr, 32'h8000_0300);
        checkOutput("coinc_out_valid", 32'(bus.out_valid), 32'h0);
        accept_pct = 0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0102, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("adef_flag", 32'(bus.out_adef), 32'h1);
        checkOutput("adef_pc", bus.out_pc, 32'h8000_0102);
        checkOutput("adef_inst", bus.out_inst, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("halt_no_req", 32'(bus.inst_req), 32'h0);
        accept_pct = 100;
        applyStimulus(1'b1, 32'h8000_0200, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("resume_addr", bus.inst_addr, 32'h8000_0200);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'hffff_fffc, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_first_addr", bus.inst_addr, 32'hffff_fffc);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_next_addr", bus.inst_addr, 32'h0000_0000);

        randomPhase(3000);
        doReset();
        randomPhase(3000);

        // Let every outstanding word and queued entry reach decode.
        accept_pct  = 0;
        latency_min = 0;
        latency_max = 0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || br_busy); i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch front end sitting directly upstream of the CPU's AXI bridge instruction port. Generates the sequential fetch PC, drives the sram-like `inst_req`/`inst_addr` handshake, and captures returned words into a small in-order queue for decode. Handles branch/exception redirects by flushing the queue and discarding any in-flight response. Flags a misaligned PC as an address-error entry instead of issuing it.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'hbfc0_0000: PC loaded on reset.

- `clk`  in  1  clock; all state on rising edge.
- `rst_p`  in  1  reset, asynchronous, active-high.
- `inst_req`  out  1  fetch request to bridge.
- `inst_addr`  out  32  fetch address (= current PC).
- `inst_addr_ok`  in  1  bridge accepted request this cycle.
- `inst_data_ok`  in  1  returned word valid this cycle.
- `inst_rdata`  in  32  returned word.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC.
- `out_valid`  out  1  queue head valid to decode.
- `out_ready`  in  1  decode consumes head.
- `out_pc`  out  32  PC of head entry.
- `out_inst`  out  32  instruction of head entry.
- `out_adef`  out  1  head is an address-error (misaligned PC) entry.

## Operation
- Registers: `pc`, `req_pc` (PC of outstanding request), FSM, circular queue of {pc, inst, adef}, `rd_ptr`/`wr_ptr` (log2 DEPTH bits, wrap naturally), `count` (log2 DEPTH + 1 bits).
- At most one request outstanding (bridge accepts one at a time).
- FSM states:
  - REQ: `inst_req = (count < DEPTH) && !redirect_valid && pc[1:0]==0`. On `inst_addr_ok`: `req_pc <= pc`, `pc <= pc + 4` (mod 2^32), → WAIT. If `pc[1:0]!=0` and `count < DEPTH` and no redirect: push {pc, 0, adef=1}, → HALT.
  - WAIT: `inst_req=0`. On `inst_data_ok` without redirect: push {req_pc, inst_rdata, 0}, → REQ. On redirect: flush, `pc <= redirect_pc`; → REQ if `inst_data_ok` same cycle (word dropped), else → DISCARD.
  - DISCARD: `inst_req=0`. On `inst_data_ok`: drop word, → REQ. Redirect here: `pc <= redirect_pc`, flush; state per same data_ok rule.
  - HALT: `inst_req=0`, no fetch until redirect; redirect → REQ with `pc <= redirect_pc`, flush.
- Redirect in REQ: flush, `pc <= redirect_pc`, stay REQ; no request issued that cycle.
- Flush: `count<=0`, `rd_ptr<=0`, `wr_ptr<=0`; any push in the same cycle is dropped.
- Pop when `out_valid && out_ready`. Push and pop in one cycle: count unchanged; allowed when full (push only happens from WAIT, whose space was reserved at issue).
- `out_valid = (count != 0) && !redirect_valid`. `out_pc/out_inst/out_adef` = head entry when `count != 0`, else 0.
- Space reservation: request issued only when `count < DEPTH`; pops only increase space, so the returned word always fits.

## Timing
- Reset (async): FSM=REQ, `pc=RESET_PC`, counts/pointers 0. Outputs: `inst_req=1` (if RESET_PC aligned) once reset deasserts, `inst_addr=RESET_PC`, `out_valid=0`, `out_pc=0`, `out_inst=0`, `out_adef=0`.
- Reset mid-operation: all state cleared immediately; an in-flight bridge response after reset is not tracked (bridge is reset by the same `rst_p`).
- `inst_req`/`inst_addr` combinational from registered state and `redirect_valid`; `inst_addr_ok` may arrive same cycle as `inst_req` rise.
- Data-to-decode latency: word on `inst_data_ok` in cycle N → `out_valid` in N+1 (registered queue).
- Best-case throughput: one instruction per 2 cycles plus bridge latency (REQ→WAIT→REQ).
- Redirect-to-new-request: redirect in cycle N in REQ → `inst_req` with `inst_addr=redirect_pc` in N+1.

## Test plan
- Reset, bridge addr_ok immediate, data_ok 2 cycles later with 32'h2408_0001 → `out_valid`, `out_pc=32'hbfc0_0000`, `out_inst=32'h2408_0001`; next `inst_addr=32'hbfc0_0004`.
- `out_ready=0`, DEPTH=4: four fetches complete → `count=4`, `inst_req` stays 0; one pop → `inst_req` re-asserts next cycle with `inst_addr=32'hbfc0_0010`.
- Redirect to 32'h8000_0100 while in WAIT; data_ok 3 cycles later → word dropped, `out_valid=0`, then `inst_req` with `inst_addr=32'h8000_0100`.
- Redirect coincident with `inst_data_ok` in WAIT → word dropped, `inst_req` next cycle at redirect_pc, no DISCARD wait.
- Redirect to 32'h8000_0102 → no request; entry `out_pc=32'h8000_0102`, `out_adef=1`, `out_inst=0`; FSM HALT until redirect to 32'h8000_0200 resumes fetch.
- PC 32'hffff_fffc fetched → next `inst_addr=32'h0000_0000` (wrap); simultaneous push/pop at full keeps `count=4`.
